// File: rtl/fork_join_ctrl_if.sv
// Fork/join control bundle between decode, subcores and the controller.
// master: decode/subcore side drives requests and done; slave: controller.
interface fork_join_ctrl_if #(
  parameter int SUBCORE_NUM = 4
);
  logic                   fork_req;
  logic [31:0]            fork_pc;
  logic                   join_req;
  logic [SUBCORE_NUM-1:0] sub_done;
  logic                   interlock;
  logic [SUBCORE_NUM-1:0] sub_start;
  logic [31:0]            sub_pc;
  logic                   fork_ack;
  logic                   join_ack;
  logic [SUBCORE_NUM-1:0] busy;
  logic [3:0]             active_cnt;
  logic                   err;

  modport master (
    output fork_req, fork_pc, join_req, sub_done,
    input  interlock, sub_start, sub_pc, fork_ack,
    input  join_ack, busy, active_cnt, err
  );

  modport slave (
    input  fork_req, fork_pc, join_req, sub_done,
    output interlock, sub_start, sub_pc, fork_ack,
    output join_ack, busy, active_cnt, err
  );
endinterface

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: allocates subcores round-robin, stalls decode.
// Ports: clk, rstn (async active-low), bus (fork_join_ctrl_if.slave).
module fork_join_ctrl #(
  parameter int SUBCORE_NUM = 4
) (
  input  logic             clk,
  input  logic             rstn,
  fork_join_ctrl_if.slave  bus
);
  localparam int N  = SUBCORE_NUM;
  localparam int PW = $clog2(N);

  typedef enum logic [1:0] {
    IDLE,
    FORK_WAIT,
    JOIN_WAIT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [N-1:0]    busy_q;
  logic [N-1:0]    busy_nxt;
  logic [N-1:0]    start_q;
  logic [N-1:0]    start_nxt;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   rr_nxt;
  logic [PW-1:0]   pick;
  logic            pick_ok;
  logic [31:0]     pc_q;
  logic            fack_q;
  logic            jack_q;
  logic            err_q;
  logic [3:0]      cnt_q;
  logic [3:0]      cnt_nxt;
  logic [N-1:0]    free;
  logic [N-1:0]    pending;
  logic            conflict;
  logic            fork_blk;
  logic            join_blk;
  logic            dispatch;
  logic            join_go;
  int              j;

  always_comb begin
    free     = ~busy_q | bus.sub_done;
    pending  = busy_q & ~bus.sub_done;
    conflict = bus.fork_req & bus.join_req;
    fork_blk = bus.fork_req & ~(|free);
    // Once waiting, only subcores not finishing this cycle hold the join.
    if (state == JOIN_WAIT)
      join_blk = bus.join_req & (|pending);
    else
      join_blk = bus.join_req & (|busy_q);
  end

  assign dispatch = ~conflict & bus.fork_req & (|free);
  assign join_go  = ~conflict & bus.join_req & ~join_blk;

  assign bus.interlock = rstn & ~conflict & (fork_blk | join_blk);

  // First free slot at or after rr_ptr, wrapping.
  always_comb begin
    pick_ok = 1'b0;
    pick    = '0;
    j       = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= N) j = j - N;
      if (!pick_ok && free[j]) begin
        pick_ok = 1'b1;
        pick    = PW'(j);
      end
    end
  end

  always_comb begin
    busy_nxt  = pending;
    start_nxt = '0;
    rr_nxt    = rr_ptr;
    if (dispatch) begin
      busy_nxt[pick]  = 1'b1;
      start_nxt[pick] = 1'b1;
      if (pick == PW'(N - 1))
        rr_nxt = '0;
      else
        rr_nxt = pick + PW'(1);
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int k = 0; k < N; k++)
      cnt_nxt = cnt_nxt + 4'(busy_nxt[k]);
  end

  always_comb begin
    state_nxt = IDLE;
    unique case (1'b1)
      conflict: state_nxt = state;
      dispatch: state_nxt = IDLE;
      fork_blk: state_nxt = FORK_WAIT;
      join_blk: state_nxt = JOIN_WAIT;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      busy_q  <= '0;
      start_q <= '0;
      rr_ptr  <= '0;
      pc_q    <= '0;
      fack_q  <= 1'b0;
      jack_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      busy_q  <= busy_nxt;
      start_q <= start_nxt;
      rr_ptr  <= rr_nxt;
      cnt_q   <= cnt_nxt;
      fack_q  <= dispatch;
      jack_q  <= join_go;
      if (dispatch)
        pc_q <= bus.fork_pc;
      // Done on an idle subcore or simultaneous fork+join are errors.
      if (conflict || (|(bus.sub_done & ~busy_q)))
        err_q <= 1'b1;
    end
  end

  assign bus.sub_start  = start_q;
  assign bus.sub_pc     = pc_q;
  assign bus.fork_ack   = fack_q;
  assign bus.join_ack   = jack_q;
  assign bus.busy       = busy_q;
  assign bus.active_cnt = cnt_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl with SUBCORE_NUM=4.
// Stimulus pushes expected acks; a negedge monitor pops and compares.
module tb_fork_join_ctrl;
  logic clk;
  logic rstn;

  fork_join_ctrl_if #(.SUBCORE_NUM(4)) bus ();

  fork_join_ctrl #(.SUBCORE_NUM(4)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    bit          is_fork;
    logic [3:0]  start;
    logic [31:0] pc;
    logic [3:0]  busy;
    logic [3:0]  cnt;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_fork(logic [3:0] s, logic [31:0] pc,
                           logic [3:0] b, logic [3:0] c);
    exp_t e;
    e.is_fork = 1'b1;
    e.start   = s;
    e.pc      = pc;
    e.busy    = b;
    e.cnt     = c;
    q.push_back(e);
  endtask

  task automatic push_join(logic [3:0] b, logic [3:0] c);
    exp_t e;
    e.is_fork = 1'b0;
    e.start   = 4'b0;
    e.pc      = 32'h0;
    e.busy    = b;
    e.cnt     = c;
    q.push_back(e);
  endtask

  task automatic idle_in();
    bus.fork_req = 1'b0;
    bus.join_req = 1'b0;
    bus.sub_done = 4'b0;
  endtask

  always @(negedge clk) begin
    if (bus.fork_ack || bus.join_ack || (|bus.sub_start)) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event fack %b jack %b start %b",
                 bus.fork_ack, bus.join_ack, bus.sub_start);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fork_ack", 32'(bus.fork_ack), 32'(e.is_fork));
        chk("join_ack", 32'(bus.join_ack), 32'(!e.is_fork));
        chk("sub_start", 32'(bus.sub_start), 32'(e.start));
        if (e.is_fork)
          chk("sub_pc", bus.sub_pc, e.pc);
        chk("busy_evt", 32'(bus.busy), 32'(e.busy));
        chk("cnt_evt", 32'(bus.active_cnt), 32'(e.cnt));
      end
    end
  end

  task automatic chk_reset_outs(string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 32'h0);
    chk({tag, "_cnt"}, 32'(bus.active_cnt), 32'h0);
    chk({tag, "_err"}, 32'(bus.err), 32'h0);
    chk({tag, "_ilk"}, 32'(bus.interlock), 32'h0);
    chk({tag, "_start"}, 32'(bus.sub_start), 32'h0);
    chk({tag, "_pc"}, bus.sub_pc, 32'h0);
    chk({tag, "_acks"}, 32'({bus.fork_ack, bus.join_ack}), 32'h0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.fork_pc = 32'h0;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outs("rst");
    rstn = 1'b1;

    // Fill all four subcores, then a fifth fork stalls.
    for (int i = 0; i < 4; i++) begin
      cyc();
      bus.fork_req = 1'b1;
      bus.fork_pc  = 32'h100 + 32'(i);
      #1;
      chk("ilk_fork", 32'(bus.interlock), 32'h0);
      push_fork(4'(1 << i), 32'h100 + 32'(i),
                4'((2 << i) - 1), 4'(i + 1));
    end
    cyc();
    bus.fork_pc = 32'h104;
    #1;
    chk("ilk_full", 32'(bus.interlock), 32'h1);
    cyc();
    chk("cnt_full", 32'(bus.active_cnt), 32'h4);
    chk("ilk_wait", 32'(bus.interlock), 32'h1);
    // Subcore 1 finishes: same-cycle reuse, busy stays full.
    bus.sub_done = 4'b0010;
    #1;
    chk("ilk_free", 32'(bus.interlock), 32'h0);
    push_fork(4'b0010, 32'h104, 4'b1111, 4'd4);
    cyc();
    idle_in();

    // Reduce to 0101, then join waits on both.
    cyc();
    bus.sub_done = 4'b1010;
    cyc();
    bus.sub_done = 4'b0000;
    chk("busy_0101", 32'(bus.busy), 32'h5);
    bus.join_req = 1'b1;
    #1;
    chk("ilk_join0", 32'(bus.interlock), 32'h1);
    cyc();
    bus.sub_done = 4'b0001;
    #1;
    chk("ilk_join1", 32'(bus.interlock), 32'h1);
    cyc();
    bus.sub_done = 4'b0000;
    #1;
    chk("ilk_join2", 32'(bus.interlock), 32'h1);
    cyc();
    bus.sub_done = 4'b0100;
    #1;
    chk("ilk_join3", 32'(bus.interlock), 32'h0);
    push_join(4'b0000, 4'd0);
    cyc();
    idle_in();

    // Join with nothing busy acks immediately.
    cyc();
    bus.join_req = 1'b1;
    #1;
    chk("ilk_join_idle", 32'(bus.interlock), 32'h0);
    push_join(4'b0000, 4'd0);
    cyc();
    idle_in();
    chk("err_pre", 32'(bus.err), 32'h0);
    bus.fork_req = 1'b1;
    bus.join_req = 1'b1;
    bus.fork_pc  = 32'h1ff;
    #1;
    chk("ilk_conflict", 32'(bus.interlock), 32'h0);
    cyc();
    idle_in();
    chk("err_conflict", 32'(bus.err), 32'h1);
    chk("busy_conflict", 32'(bus.busy), 32'h0);

    // Reset clears err; spurious done sets it again.
    rstn = 1'b0;
    cyc();
    rstn = 1'b1;
    chk("err_cleared", 32'(bus.err), 32'h0);
    cyc();
    bus.sub_done = 4'b1000;
    cyc();
    bus.sub_done = 4'b0000;
    chk("err_done", 32'(bus.err), 32'h1);
    chk("busy_done", 32'(bus.busy), 32'h0);

    // Two forks, then reset in the middle of a join wait.
    for (int i = 0; i < 2; i++) begin
      bus.fork_req = 1'b1;
      bus.fork_pc  = 32'h200 + 32'(4 * i);
      push_fork(4'(1 << i), 32'h200 + 32'(4 * i),
                4'((2 << i) - 1), 4'(i + 1));
      cyc();
    end
    idle_in();
    bus.join_req = 1'b1;
    #1;
    chk("ilk_jw", 32'(bus.interlock), 32'h1);
    cyc();
    cyc();
    rstn = 1'b0;
    #1;
    chk_reset_outs("mid");
    bus.join_req = 1'b0;
    repeat (2) cyc();
    rstn = 1'b1;
    repeat (3) cyc();

    // First fork after reset starts from subcore 0.
    bus.fork_req = 1'b1;
    bus.fork_pc  = 32'h300;
    push_fork(4'b0001, 32'h300, 4'b0001, 4'd1);
    cyc();
    idle_in();
    repeat (4) cyc();

    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fork_join_ctrl.md
FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

Interface
REQ-001 Parameter SUBCORE_NUM, default 4, number of subcores managed (2..8).
REQ-002 clk  in  1  system clock, all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 fork_req  in  1  decode holds a Fork instruction this cycle.
REQ-005 fork_pc  in  32  start PC for the forked subcore.
REQ-006 join_req  in  1  decode holds a Join instruction this cycle.
REQ-007 sub_done  in  SUBCORE_NUM  one-cycle completion pulse per subcore.
REQ-008 interlock  out  1  combinational stall to the main pipeline.
REQ-009 sub_start  out  SUBCORE_NUM  registered one-cycle start pulse per subcore.
REQ-010 sub_pc  out  32  registered start PC, valid with any sub_start bit.
REQ-011 fork_ack  out  1  registered pulse: a fork was dispatched.
REQ-012 join_ack  out  1  registered pulse: a join completed.
REQ-013 busy  out  SUBCORE_NUM  registered per-subcore occupancy.
REQ-014 active_cnt  out  4  registered popcount of busy.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 States: IDLE, FORK_WAIT, JOIN_WAIT; stored in a register.
REQ-017 free = ~busy | sub_done (a completing subcore is allocatable in the same cycle).
REQ-018 Allocation: first free index at or after rr_ptr, wrapping modulo SUBCORE_NUM; rr_ptr <= chosen+1 mod SUBCORE_NUM on dispatch.
REQ-019 Dispatch (IDLE or FORK_WAIT, fork_req, free!=0): next edge sub_start[i]=1, sub_pc=fork_pc, busy[i]=1, fork_ack=1, state=IDLE; interlock=0 that cycle.
REQ-020 fork_req with free==0: interlock=1, state=FORK_WAIT; dispatch occurs in the first cycle free!=0, fork_pc sampled in that cycle.
REQ-021 join_req in IDLE with busy==0: interlock=0, join_ack=1 next edge.
REQ-022 join_req with busy!=0: interlock=1, state=JOIN_WAIT; stays until (busy & ~sub_done)==0, that cycle interlock=0, join_ack=1 next edge, state=IDLE.
REQ-023 sub_done[i] clears busy[i] at next edge unless the same index is re-dispatched that edge (dispatch wins, busy stays 1).
REQ-024 sub_done[i] with busy[i]==0 sets err; bit ignored otherwise.
REQ-025 fork_req and join_req in the same cycle: err set, neither served, interlock=0, no state change.
REQ-026 sub_start, fork_ack, join_ack are single-cycle; deasserted on all other cycles.
REQ-027 active_cnt equals popcount of the busy value registered the same edge.
REQ-028 interlock depends only on state, requests, busy, sub_done; no path from sub_start.

Reset
REQ-029 rstn low asynchronously: state=IDLE, busy=0, rr_ptr=0, active_cnt=0, sub_start=0, sub_pc=0, fork_ack=0, join_ack=0, err=0; interlock=0 while rstn low.
REQ-030 Reset mid-FORK_WAIT or mid-JOIN_WAIT abandons the pending request; no ack emitted after release.
REQ-031 First edge after rstn rises behaves as IDLE with busy=0.

Verification
REQ-032 N=4, five fork_req with fork_pc 0x100..0x104, no done -> sub_start 0001,0010,0100,1000, fifth holds interlock=1, FORK_WAIT.
REQ-033 Continuing, sub_done=0010 -> same cycle interlock=0, next edge sub_start=0010, sub_pc=0x104, busy=1111, active_cnt=4.
REQ-034 busy=0101, join_req held; done 0001 then 0100 two cycles later -> interlock high until done 0100 cycle, join_ack one cycle later, busy=0.
REQ-035 busy=0, join_req -> interlock=0, join_ack next edge; fork_req+join_req together -> err=1, no ack, busy unchanged.
REQ-036 sub_done=1000 with busy=0000 -> err=1, busy unchanged; rstn low mid-JOIN_WAIT -> all outputs zero immediately, no join_ack after release.
